// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the RX FSM) and line levels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // Gray-coded so adjacent states differ in one bit; the RX FSM uses the same encoding
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b011,
        PARITY = 3'b010,
        STOP   = 3'b110
    } state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data-bit shifter: holds the frame payload and counts the data bits already presented.
// Latency: ser_data shows bit 0 the cycle after load; each shift_en exposes the next bit.
// Backpressure: none; the FSM alone decides when to load and shift.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  ser_data,
    output logic                  ser_done
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_q;
    logic [3:0]            bit_cnt;

    // Load a fresh byte on acceptance, otherwise shift right once per data cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shift_q <= P_DATA;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

    assign ser_data = shift_q[0];
    assign ser_done = (bit_cnt == LAST_BIT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit; one bit per CLK.
// Latency: start bit appears on TX_OUT one edge after the accepting edge; frame is DATA_WIDTH+2(+1) cycles.
// Backpressure: none; DATA_VALID is only honoured in IDLE or STOP, elsewhere it is silently dropped.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    state_t state;
    logic   par_en_q;
    logic   par_bit;
    logic   ser_data;
    logic   ser_done;
    logic   accept;
    logic   shift_en;

    // STOP is an accept point so frames can run back to back without an idle gap
    assign accept   = DATA_VALID && ((state == IDLE) || (state == STOP));
    assign shift_en = (state == DATA);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (accept),
        .shift_en (shift_en),
        .P_DATA   (P_DATA),
        .ser_data (ser_data),
        .ser_done (ser_done)
    );

    // Frame FSM; TX_OUT/busy are registered from the current state, so they trail it by one edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            TX_OUT   <= STOP_BIT;
            busy     <= 1'b0;
            par_en_q <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            // Parity options are frozen with the byte so mid-frame input changes cannot leak in
            if (accept) begin
                par_en_q <= PAR_EN;
                par_bit  <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
            end
            case (state)
                IDLE: begin
                    TX_OUT <= STOP_BIT;
                    busy   <= 1'b0;
                    if (DATA_VALID) state <= START;
                end
                START: begin
                    TX_OUT <= START_BIT;
                    busy   <= 1'b1;
                    state  <= DATA;
                end
                DATA: begin
                    TX_OUT <= ser_data;
                    busy   <= 1'b1;
                    if (ser_done) state <= par_en_q ? PARITY : STOP;
                end
                PARITY: begin
                    TX_OUT <= par_bit;
                    busy   <= 1'b1;
                    state  <= STOP;
                end
                STOP: begin
                    TX_OUT <= STOP_BIT;
                    busy   <= 1'b1;
                    state  <= DATA_VALID ? START : IDLE;
                end
                default: begin
                    // Unreachable encodings fall back to an idle line
                    TX_OUT <= STOP_BIT;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] P_DATA = 8'h00;
    logic       DATA_VALID = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic        noise;
        int          len;
        logic [15:0] frame;   // expected line bits, bit 0 = first (start) bit
    } vec_t;

    vec_t vecs [6];

    // Reference model: queue of line bits still owed for upcoming edges
    logic model_q [$];

    // Drive one set of inputs, let one rising edge consume them, settle past the edge
    task automatic step(input logic rst, input logic dv, input logic [7:0] d,
                        input logic pe, input logic pt);
        RST = rst; DATA_VALID = dv; P_DATA = d; PAR_EN = pe; PAR_TYP = pt;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic exp_tx, input logic exp_busy);
        checks++;
        if ({TX_OUT, busy} !== {exp_tx, exp_busy}) begin
            errors++;
            $display("FAIL %s: got tx=%b busy=%b, want tx=%b busy=%b",
                     name, TX_OUT, busy, exp_tx, exp_busy);
        end
    endtask

    // Model of one edge: what the line shows at that edge, and any new frame it starts
    task automatic model_edge(input logic rst, input logic dv, input logic [7:0] d,
                              input logic pe, input logic pt,
                              output logic exp_tx, output logic exp_busy);
        logic can_accept;
        if (rst) begin
            model_q.delete();
            exp_tx = 1'b1; exp_busy = 1'b0;
        end else begin
            // Line is idle or about to show its final stop bit
            can_accept = (model_q.size() <= 1);
            if (model_q.size() > 0) begin
                exp_tx = model_q.pop_front(); exp_busy = 1'b1;
            end else begin
                exp_tx = 1'b1; exp_busy = 1'b0;
            end
            if (dv && can_accept) begin
                model_q.push_back(1'b0);
                for (int i = 0; i < 8; i++) model_q.push_back(d[i]);
                if (pe) model_q.push_back((($countones(d) % 2) == 1) ^ pt);
                model_q.push_back(1'b1);
            end
        end
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, noise: 1'b0, len: 10, frame: 16'h034A};
        vecs[1] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, noise: 1'b0, len: 11, frame: 16'h054A};
        vecs[2] = '{data: 8'hA5, pe: 1'b1, pt: 1'b1, noise: 1'b0, len: 11, frame: 16'h074A};
        vecs[3] = '{data: 8'h07, pe: 1'b1, pt: 1'b0, noise: 1'b0, len: 11, frame: 16'h060E};
        vecs[4] = '{data: 8'h81, pe: 1'b0, pt: 1'b0, noise: 1'b1, len: 10, frame: 16'h0302};
        vecs[5] = '{data: 8'h3C, pe: 1'b0, pt: 1'b1, noise: 1'b1, len: 10, frame: 16'h0278};

        // Reset for two edges, then a quiet line for 20 cycles
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("reset_edge1", 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("reset_edge2", 1'b1, 1'b0);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            check($sformatf("idle_after_reset_c%0d", c), 1'b1, 1'b0);
        end

        // Table-driven single frames; noisy records wiggle inputs while the frame is in flight
        for (int v = 0; v < 6; v++) begin
            step(1'b0, 1'b1, vecs[v].data, vecs[v].pe, vecs[v].pt);
            check($sformatf("vec%0d_accept_edge", v), 1'b1, 1'b0);
            for (int i = 0; i < vecs[v].len; i++) begin
                logic [15:0] fr;
                fr = vecs[v].frame;
                if (vecs[v].noise && i < vecs[v].len - 1)
                    step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                else
                    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
                check($sformatf("vec%0d_bit%0d", v, i), fr[i], 1'b1);
            end
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            check($sformatf("vec%0d_end_idle", v), 1'b1, 1'b0);
        end

        // Back to back: 0x3C then 0xFF with DATA_VALID held through the first stop cycle
        begin
            logic [19:0] b2b;
            b2b = {10'h3FE, 10'h278};
            step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
            check("b2b_accept_edge", 1'b1, 1'b0);
            for (int i = 0; i < 20; i++) begin
                if (i < 10) step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
                else        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
                check($sformatf("b2b_bit%0d", i), b2b[i], 1'b1);
            end
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            check("b2b_end_idle", 1'b1, 1'b0);
        end

        // Reset during the 4th data bit abandons the frame; a later 0x81 goes out cleanly
        begin
            logic [9:0] f81;
            f81 = 10'h302;
            step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            check("midrst_busy_before", TX_OUT, 1'b1);
            step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
            check("midrst_reset_edge", 1'b1, 1'b0);
            for (int c = 0; c < 3; c++) begin
                step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
                check($sformatf("midrst_idle_c%0d", c), 1'b1, 1'b0);
            end
            step(1'b0, 1'b1, 8'h81, 1'b0, 1'b0);
            for (int i = 0; i < 10; i++) begin
                step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
                check($sformatf("post_rst_0x81_bit%0d", i), f81[i], 1'b1);
            end
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            check("post_rst_0x81_idle", 1'b1, 1'b0);
        end

        // Randomized traffic against the frame-queue model (line is idle here)
        model_q.delete();
        for (int c = 0; c < 600; c++) begin
            logic       r, dv, pe, pt, etx, ebusy;
            logic [7:0] d;
            r  = ($urandom_range(0, 79) == 0);
            dv = ($urandom_range(0, 2) == 0);
            d  = 8'($urandom);
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            model_edge(r, dv, d, pe, pt, etx, ebusy);
            step(r, dv, d, pe, pt);
            check($sformatf("rand_c%0d", c), etx, ebusy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter, the transmit end of the same link served by the RX path's FSM_RX.
- Accepts a parallel byte with a valid strobe and serializes it onto TX_OUT, LSB first: start bit (0), DATA_WIDTH data bits, optional parity bit, one stop bit (1).
- CLK is the TX bit clock: exactly one frame bit per CLK cycle. Baud division happens upstream in the clock divider.
- Sits between the system-control/FIFO read side and the TX pin.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (4..16).

Ports:
- CLK  input  1  TX bit clock; all logic on its rising edge.
- RST  input  1  synchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  parallel byte to send; sampled only on acceptance.
- DATA_VALID  input  1  request strobe; a byte is accepted when DATA_VALID=1 at an accept point.
- PAR_EN  input  1  1 = insert parity bit; sampled on acceptance.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance.
- TX_OUT  output  1  serial line; registered; idle high.
- busy  output  1  registered; high for every cycle TX_OUT carries a frame bit.

Behaviour:
- Reset, synchronous with RST=1 at a CLK edge:
  - State goes to IDLE, TX_OUT=1, busy=0.
  - The shift register, bit counter and latched PAR_EN/PAR_TYP/parity bit clear to 0.
  - Reset mid-frame abandons the frame. TX_OUT is 1 from the next edge; no partial stop bit is generated.
- States use Gray encoding: IDLE=000, START=001, DATA=011, PARITY=010, STOP=110.
- Accept points:
  - IDLE, or the STOP cycle (back-to-back).
  - At an accept point with DATA_VALID=1, the edge latches P_DATA, PAR_EN, PAR_TYP and computes parity = (^P_DATA) ^ PAR_TYP.
  - DATA_VALID in START/DATA/PARITY is ignored. No buffering, no error flag.
- Timing, with acceptance at edge k:
  - Edge k+1: TX_OUT=0 (start bit), busy=1.
  - Edges k+2 .. k+1+DATA_WIDTH: data bits, LSB first.
  - If latched PAR_EN=1: one cycle of the parity bit.
  - Then one cycle of TX_OUT=1 (stop bit).
  - Frame length is DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity.
- Transitions:
  - IDLE -> START on DATA_VALID; otherwise stay in IDLE with TX_OUT=1, busy=0.
  - START -> DATA always (one cycle).
  - DATA: 4-bit bit counter counts 0..DATA_WIDTH-1. When count = DATA_WIDTH-1, go to PARITY if latched PAR_EN=1, else to STOP.
  - PARITY -> STOP (one cycle).
  - STOP -> START if DATA_VALID=1 (new byte latched, no idle gap; busy stays 1). Otherwise STOP -> IDLE (TX_OUT=1, busy=0 on the next edge).
- The shift register shifts right one position per DATA cycle. TX_OUT is driven from a registered mux: start=0, data=shift[0], parity=par_bit, stop/idle=1.
- Changing P_DATA, PAR_EN or PAR_TYP mid-frame has no effect on the frame in flight.
- Illegal state encodings recover to IDLE on the next edge with TX_OUT=1.
- The block never drives X on TX_OUT or busy after the first reset edge.

Decomposition:
- Package uart_pkg holds:
  - state localparams IDLE/START/DATA/PARITY/STOP (shared encoding with the RX FSM, width 3);
  - PAR_EVEN=1'b0, PAR_ODD=1'b1;
  - START_BIT=1'b0, STOP_BIT=1'b1.
- One sub-module, uart_tx_serializer:
  - contains the DATA_WIDTH shift register and the bit counter;
  - inputs: load, shift_en, P_DATA;
  - outputs: ser_data and ser_done (count = DATA_WIDTH-1).
- The FSM, parity latch and output mux stay in uart_tx.

Test Plan:
- Reset: RST=1 for 2 cycles, then 0, DATA_VALID=0 for 20 cycles -> TX_OUT=1 and busy=0 throughout.
- 0xA5, PAR_EN=0: DATA_VALID pulse at edge k -> TX_OUT over edges k+1..k+10 is 0,1,0,1,0,0,1,0,1,1; busy=1 for exactly those 10 cycles, 0 at k+11.
- 0xA5 with parity:
  - PAR_EN=1, PAR_TYP=0 -> bit 10 of the frame is 0 (4 ones), frame length 11.
  - Repeat with PAR_TYP=1 -> parity bit is 1.
  - 0x07, PAR_TYP=0 -> parity bit is 1.
- Back-to-back: 0x3C then 0xFF (PAR_EN=0), DATA_VALID held high through the first STOP cycle -> the second start bit immediately follows the stop bit, busy never drops, 20 frame cycles total. DATA_VALID toggled during DATA -> ignored, frame unchanged.
- Reset mid-frame: RST=1 during the 4th data bit -> TX_OUT=1 and busy=0 from the next edge. A new 0x81 sent afterwards is transmitted correctly: 0,1,0,0,0,0,0,0,1,1.
